median3x3_stream: RTL
=====================

// Module: median3x3_stream
// PURPOSE
//  Streaming 3x3 median noise detector and filter; generalises the 3-input sort block to a pipelined window.
//  - Accepts one pixel column (top/mid/bot) per handshake and keeps a sliding window of the last three columns.
//  - Outputs the window median, an impulse-noise flag for the centre pixel, and the corrected pixel.
//  - Sits between the line-buffer column feeder and the denoised-image writer.
// PARAMETERS
//  DATA_WIDTH  8   pixel width in bits, unsigned
//  THRESH      32  noise threshold; flag is set when |centre - median| > THRESH (width DATA_WIDTH)
// PORTS
//  clk        in   1           clock; all state is updated on the rising edge
//  rst        in   1           asynchronous reset, active-high
//  in_valid   in   1           column valid
//  in_ready   out  1           block can accept a column
//  in_sol     in   1           start of line; qualified by in_valid & in_ready
//  col_top    in   DATA_WIDTH  column pixel, row y-1
//  col_mid    in   DATA_WIDTH  column pixel, row y
//  col_bot    in   DATA_WIDTH  column pixel, row y+1
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts the result
//  med_out    out  DATA_WIDTH  3x3 median
//  noisy      out  1           centre pixel flagged as impulse noise
//  pix_out    out  DATA_WIDTH  corrected pixel: noisy ? med_out : centre
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valids, out_valid, med_out, noisy, pix_out and the fill counter go to 0; window registers go to 0.
//  - Global enable: en = !out_valid | out_ready, and in_ready = en. A column is accepted when in_valid & en.
//  - Stall (en=0): every pipeline register, including the outputs, holds its value.
//  - S1, on accept:
//    - sort the column into min/med/max, using the same compare rules as the 3-input sort block;
//    - shift it into the sorted window W0 (newest) -> W1 -> W2, and keep the raw col_mid alongside each column.
//  - Fill counter: saturates at 3.
//    - Accept with in_sol=1: counter = 1. Older columns become don't-care, and no result is emitted for them.
//    - Accept with in_sol=0: counter = min(counter+1, 3).
//    - S1 valid = accepted & (new counter == 3).
//  - S2: A = max(W0.min, W1.min, W2.min), B = med(W0.med, W1.med, W2.med), C = min(W0.max, W1.max, W2.max).
//    - The centre is raw mid of W1, piped along with A, B, C.
//  - S3: median = med(A, B, C); diff = |centre - median| (unsigned, no wrap); noisy = diff > THRESH; pix_out = noisy ? median : centre.
//  - Latency: 3 enabled cycles from the accept of the 3rd column to out_valid=1.
//  - Throughput: 1 result per cycle after fill, while out_ready=1.
//  - out_valid stays high, with stable data, until out_ready=1.
//  - Equal inputs: any tie order is acceptable; the median value is unique.
//  - diff == THRESH gives noisy=0. THRESH=0 flags any non-equal centre.
//  - in_sol with the counter already at 3: new line, and no result is emitted until 3 more columns have been accepted.
//  - rst mid-stream: in-flight results are discarded; after release, 3 columns are needed before the next result.
//  - Inputs are sampled only on accept; values while in_valid=0 are ignored.
// TESTING
//  - Reset: rst=1 with random inputs -> out_valid=0, med_out=0, noisy=0, pix_out=0; in_ready=1 after release.
//  - Ramp (out_ready=1, THRESH=32): sol+(10,20,30), (40,50,60), (70,80,90) -> 3 cycles after the 3rd accept: med_out=50, noisy=0, pix_out=50.
//  - Impulse: columns (100,100,100), (100,255,100), (100,100,100) -> med_out=100, noisy=1, pix_out=100.
//    Centre 132 in the same frame (diff==32) -> noisy=0, pix_out=132.
//  - Line restart: 2 columns, then sol+(145,145,145) x3 -> only one result, med_out=145, noisy=0; no result from the pre-sol columns.
//  - Backpressure: continuous stream with out_ready=0 for 5 cycles.
//    -> in_ready=0 while out_valid=1; outputs stay stable; no result is lost or duplicated when out_ready returns to 1.
//  - Reset mid-fill: 2 columns accepted, rst pulse -> out_valid stays 0 until 3 new columns have been accepted.

Source files
------------

// File: rtl/median3x3_if.sv
// Column-in / result-out stream bundle for the 3x3 median filter.
// Handshake: a transfer happens on a rising edge where valid && ready; the source holds data stable while valid && !ready.
interface median3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sol;
  logic [DATA_WIDTH-1:0] col_top;
  logic [DATA_WIDTH-1:0] col_mid;
  logic [DATA_WIDTH-1:0] col_bot;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] med_out;
  logic                  noisy;
  logic [DATA_WIDTH-1:0] pix_out;

  modport master (
    output in_valid, in_sol, col_top, col_mid, col_bot, out_ready,
    input  in_ready, out_valid, med_out, noisy, pix_out
  );

  modport slave (
    input  in_valid, in_sol, col_top, col_mid, col_bot, out_ready,
    output in_ready, out_valid, med_out, noisy, pix_out
  );
endinterface

// File: rtl/median3x3_stream.sv
// Three-stage 3x3 median filter: column sort + window shift, row-of-extremes reduction, final median and
// impulse-noise correction. A single enable stalls the whole pipeline when the output is held.
module median3x3_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int THRESH     = 32
) (
  input logic         clk,
  input logic         rst,
  median3x3_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] THR = W'(THRESH);

  function automatic logic [W-1:0] min2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [W-1:0] med3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic         en;
  logic         accept;
  logic [1:0]   fill;
  logic [1:0]   fill_next;
  logic         s1_valid;
  logic [W-1:0] w_min [3];
  logic [W-1:0] w_med [3];
  logic [W-1:0] w_max [3];
  logic [W-1:0] w_mid [3];

  logic         s2_valid;
  logic [W-1:0] s2_a, s2_b, s2_c, s2_centre;

  logic [W-1:0] median;
  logic [W-1:0] diff;
  logic         flag;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign accept       = bus.in_valid && en;

  always_comb begin
    fill_next = fill;
    if (bus.in_sol)       fill_next = 2'd1;
    else if (fill != 2'd3) fill_next = fill + 2'd1;
  end

  // S1: sort the incoming column and shift it into the window, newest at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill     <= 2'd0;
      s1_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        w_min[i] <= '0;
        w_med[i] <= '0;
        w_max[i] <= '0;
        w_mid[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= accept && (fill_next == 2'd3);
      if (accept) begin
        fill     <= fill_next;
        w_min[0] <= min2(min2(bus.col_top, bus.col_mid), bus.col_bot);
        w_med[0] <= med3(bus.col_top, bus.col_mid, bus.col_bot);
        w_max[0] <= max2(max2(bus.col_top, bus.col_mid), bus.col_bot);
        w_mid[0] <= bus.col_mid;
        for (int i = 1; i < 3; i++) begin
          w_min[i] <= w_min[i-1];
          w_med[i] <= w_med[i-1];
          w_max[i] <= w_max[i-1];
          w_mid[i] <= w_mid[i-1];
        end
      end
    end
  end

  // S2: the 9-value median equals med(max of mins, med of meds, min of maxes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_c      <= '0;
      s2_centre <= '0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_a      <= max2(max2(w_min[0], w_min[1]), w_min[2]);
      s2_b      <= med3(w_med[0], w_med[1], w_med[2]);
      s2_c      <= min2(min2(w_max[0], w_max[1]), w_max[2]);
      s2_centre <= w_mid[1];
    end
  end

  assign median = med3(s2_a, s2_b, s2_c);
  assign diff   = (s2_centre >= median) ? (s2_centre - median) : (median - s2_centre);
  assign flag   = diff > THR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.med_out   <= '0;
      bus.noisy     <= 1'b0;
      bus.pix_out   <= '0;
    end else if (en) begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.med_out <= median;
        bus.noisy   <= flag;
        bus.pix_out <= flag ? median : s2_centre;
      end
    end
  end
endmodule
